// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: rotation (sin/cos) and vectoring (magnitude/atan2)
// with quadrant pre-rotation, one micro-rotation per clock, start/busy/done handshake.
module cordic_engine #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ITER   = 16,
    parameter int          K_INIT = 6_072_529
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] angle_in,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IW = 5;
    localparam logic signed [WIDTH-1:0] DEG90 = WIDTH'(900_000_000);
    localparam logic signed [WIDTH-1:0] KI    = WIDTH'(K_INIT);
    localparam logic [IW-1:0]           LAST  = IW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_next;
    logic signed [WIDTH-1:0] x, y, z;
    logic signed [WIDTH-1:0] x_next, y_next, z_next;
    logic signed [WIDTH-1:0] xo_next, yo_next, zo_next;
    logic [IW-1:0]           i, i_next;
    logic                    mode_q, mode_next;
    logic                    busy_next, done_next;
    logic signed [WIDTH-1:0] x_sh, y_sh, atan_i;
    logic                    dir_pos;

    // atan(2^-i) in degrees scaled by 1e7
    function automatic logic signed [WIDTH-1:0] atan_lut(input logic [IW-1:0] idx);
        logic [31:0] v;
        case (idx)
            5'd0:    v = 32'd450_000_000;
            5'd1:    v = 32'd265_650_512;
            5'd2:    v = 32'd140_362_435;
            5'd3:    v = 32'd71_250_163;
            5'd4:    v = 32'd35_763_344;
            5'd5:    v = 32'd17_899_106;
            5'd6:    v = 32'd8_951_737;
            5'd7:    v = 32'd4_476_142;
            5'd8:    v = 32'd2_238_105;
            5'd9:    v = 32'd1_119_057;
            5'd10:   v = 32'd559_529;
            5'd11:   v = 32'd279_765;
            5'd12:   v = 32'd139_882;
            5'd13:   v = 32'd69_941;
            5'd14:   v = 32'd34_971;
            5'd15:   v = 32'd17_485;
            5'd16:   v = 32'd8_743;
            5'd17:   v = 32'd4_371;
            5'd18:   v = 32'd2_186;
            5'd19:   v = 32'd1_093;
            5'd20:   v = 32'd546;
            5'd21:   v = 32'd273;
            5'd22:   v = 32'd137;
            5'd23:   v = 32'd68;
            default: v = 32'd0;
        endcase
        return WIDTH'(v);
    endfunction

    // Shared shift datapath and rotation direction for the current iteration
    always_comb begin
        x_sh    = x >>> i;
        y_sh    = y >>> i;
        atan_i  = atan_lut(i);
        dir_pos = mode_q ? y[WIDTH-1] : ~z[WIDTH-1];
    end

    // Next-state and next-register logic
    always_comb begin
        state_next = state;
        x_next     = x;
        y_next     = y;
        z_next     = z;
        i_next     = i;
        mode_next  = mode_q;
        busy_next  = busy;
        done_next  = 1'b0;
        xo_next    = x_out;
        yo_next    = y_out;
        zo_next    = z_out;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_next  = mode;
                    i_next     = '0;
                    busy_next  = 1'b1;
                    state_next = RUN;
                    if (!mode) begin
                        if (angle_in > DEG90) begin
                            x_next = '0;
                            y_next = KI;
                            z_next = angle_in - DEG90;
                        end else if (angle_in < -DEG90) begin
                            x_next = '0;
                            y_next = -KI;
                            z_next = angle_in + DEG90;
                        end else begin
                            x_next = KI;
                            y_next = '0;
                            z_next = angle_in;
                        end
                    end else begin
                        if (x_in[WIDTH-1] && !y_in[WIDTH-1]) begin
                            x_next = y_in;
                            y_next = -x_in;
                            z_next = DEG90;
                        end else if (x_in[WIDTH-1]) begin
                            x_next = -y_in;
                            y_next = x_in;
                            z_next = -DEG90;
                        end else begin
                            x_next = x_in;
                            y_next = y_in;
                            z_next = '0;
                        end
                    end
                end
            end
            RUN: begin
                if (dir_pos) begin
                    x_next = x - y_sh;
                    y_next = y + x_sh;
                    z_next = z - atan_i;
                end else begin
                    x_next = x + y_sh;
                    y_next = y - x_sh;
                    z_next = z + atan_i;
                end
                i_next = i + 1'b1;
                if (i == LAST) begin
                    busy_next  = 1'b0;
                    state_next = DONE;
                end
            end
            DONE: begin
                xo_next    = x;
                yo_next    = y;
                zo_next    = z;
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Datapath, handshake and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            z      <= '0;
            i      <= '0;
            mode_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else begin
            x      <= x_next;
            y      <= y_next;
            z      <= z_next;
            i      <= i_next;
            mode_q <= mode_next;
            busy   <= busy_next;
            done   <= done_next;
            x_out  <= xo_next;
            y_out  <= yo_next;
            z_out  <= zo_next;
        end
    end

endmodule

// File: tb/tb_cordic_engine.sv
// Testbench for cordic_engine: directed and random operations against a
// floating-point trigonometric reference.
module tb_cordic_engine;

    localparam int unsigned W    = 32;
    localparam int unsigned ITER = 16;
    localparam real         PI   = 3.14159265358979323846;
    localparam real         GAIN = 1.64676;

    logic                clk = 1'b0;
    logic                rst, start, mode;
    logic signed [W-1:0] angle_in, x_in, y_in;
    logic signed [W-1:0] x_out, y_out, z_out;
    logic                busy, done;

    int checks = 0;
    int errors = 0;

    cordic_engine #(.WIDTH(W), .ITER(ITER), .K_INIT(6_072_529)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .angle_in(angle_in), .x_in(x_in), .y_in(y_in),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input longint obs, input real exp, input real tol);
        real d;
        d = real'(obs) - exp;
        if (d < 0.0) d = -d;
        checks++;
        assert ((d <= tol) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0.1f tol=%0.0f", tag, obs, exp, tol);
        end
    endtask

    task automatic launch(input logic m, input longint a, input longint xi, input longint yi);
        mode     = m;
        angle_in = W'(a);
        x_in     = W'(xi);
        y_in     = W'(yi);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic run_rot(input string tag, input longint a);
        real r;
        int  n;
        r = real'(a) / 1.0e7 * PI / 180.0;
        launch(1'b0, a, 0, 0);
        check_eq({tag, "_busy"}, longint'(busy), 1);
        wait_done(n);
        check_eq({tag, "_lat"}, longint'(n), longint'(ITER + 1));
        check_near({tag, "_x"}, longint'(x_out), 1.0e7 * $cos(r), 500.0);
        check_near({tag, "_y"}, longint'(y_out), 1.0e7 * $sin(r), 500.0);
        check_near({tag, "_z"}, longint'(z_out), 0.0, 20_000.0);
    endtask

    task automatic run_vec(input string tag, input longint xi, input longint yi);
        real fx, fy;
        int  n;
        fx = real'(xi);
        fy = real'(yi);
        launch(1'b1, 0, xi, yi);
        wait_done(n);
        check_eq({tag, "_lat"}, longint'(n), longint'(ITER + 1));
        check_near({tag, "_z"}, longint'(z_out), $atan2(fy, fx) * 180.0 / PI * 1.0e7, 20_000.0);
        check_near({tag, "_x"}, longint'(x_out), GAIN * $sqrt(fx * fx + fy * fy), 500.0);
        check_near({tag, "_y"}, longint'(y_out), 0.0, 500.0);
    endtask

    initial begin
        int     dones;
        int     last;
        int     seen;
        longint a, m, xi, yi;
        real    th;

        rst = 1'b1; start = 1'b0; mode = 1'b0;
        angle_in = '0; x_in = '0; y_in = '0;
        #2;
        check_eq("rst_x", longint'(x_out), 0);
        check_eq("rst_y", longint'(y_out), 0);
        check_eq("rst_z", longint'(z_out), 0);
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_done", longint'(done), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed rotation and vectoring points
        run_rot("rot30", 300_000_000);
        run_rot("rot150", 1_500_000_000);
        run_rot("rotm120", -1_200_000_000);
        run_vec("vec34", 3_000_000, 4_000_000);
        run_vec("vec_negx", -1_000_000, 0);
        run_vec("vec_q3", -1_000_000, -1_000_000);

        // Extra start pulses while busy are ignored
        launch(1'b0, 300_000_000, 0, 0);
        angle_in = -W'(1_200_000_000);
        dones = 0;
        for (int c = 1; c <= 30; c++) begin
            start = (c == 3 || c == 10);
            @(posedge clk); #1;
            if (done) dones++;
        end
        start = 1'b0;
        check_eq("busy_pulse_dones", longint'(dones), 1);
        check_near("busy_pulse_x", longint'(x_out), 8_660_254.0, 500.0);
        check_near("busy_pulse_y", longint'(y_out), 5_000_000.0, 500.0);

        // Start in the DONE cycle is ignored
        launch(1'b0, 0, 0, 0);
        dones = 0;
        for (int c = 1; c <= 19; c++) begin
            start = (c == 17);
            @(posedge clk); #1;
            if (done) dones++;
            if (c == 18) check_eq("done_cycle_busy", longint'(busy), 0);
        end
        start = 1'b0;
        check_eq("done_cycle_dones", longint'(dones), 1);

        // Start held high: back-to-back operations every ITER+2 cycles
        mode = 1'b0; angle_in = '0; start = 1'b1;
        last = -1; seen = 0;
        for (int c = 1; c <= 100 && seen < 4; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (last >= 0) check_eq("held_gap", longint'(c - last), longint'(ITER + 2));
                last = c;
                seen++;
            end
        end
        start = 1'b0;
        check_eq("held_count", longint'(seen), 4);
        check_near("held_x", longint'(x_out), 1.0e7, 500.0);

        // Reset mid-operation aborts without a done pulse
        launch(1'b0, 600_000_000, 0, 0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst_x", longint'(x_out), 0);
        check_eq("midrst_y", longint'(y_out), 0);
        check_eq("midrst_z", longint'(z_out), 0);
        check_eq("midrst_busy", longint'(busy), 0);
        check_eq("midrst_done", longint'(done), 0);
        @(posedge clk); #1 rst = 1'b0;
        dones = 0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check_eq("midrst_nodone", longint'(dones), 0);
        run_rot("post_rst", 450_000_000);

        // Random rotations over the full range
        for (int k = 0; k < 12; k++) begin
            a = longint'($urandom_range(32'd3_600_000_000, 32'd0)) - 1_800_000_000;
            run_rot("rnd_rot", a);
        end

        // Random vectors with magnitude 1e6..5e6 in all quadrants
        for (int k = 0; k < 12; k++) begin
            m  = longint'($urandom_range(5_000_000, 1_000_000));
            th = real'($urandom_range(359_999, 0)) / 1000.0 - 180.0;
            xi = longint'($rtoi(real'(m) * $cos(th * PI / 180.0)));
            yi = longint'($rtoi(real'(m) * $sin(th * PI / 180.0)));
            run_vec("rnd_vec", xi, yi);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
